pwm_ramp: RTL and testbench

Slew-limited setpoint generator that sits directly upstream of the 16-bit PWM stage and drives its `val`/`set_val` load interface. Accepts 16-bit duty targets over a valid/ready handshake and moves the output value toward the target by at most `STEP` counts per update tick. Each change is published with a single-cycle `set_val` strobe, and `val` is held stable around the strobe. With the defaults, one tick equals one 65536-cycle PWM period, so the duty changes at most once per PWM period.

---
 rtl/pwm_ramp.sv | 138 +++++++++++++
 tb/tb_pwm_ramp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp.sv
// pwm_ramp: slew-limited duty setpoint generator feeding the PWM val/set_val load port.
// Latency: a tick in cycle N updates val at the end of N; set_val pulses during N+2.
// Backpressure: target_ready is low during LOAD/STROBE and in reset; held targets wait.
// Optional feature: define PWM_RAMP_CLAMP_EN to clamp accepted targets to MAX_VAL.
module pwm_ramp #(
  parameter int unsigned STEP     = 64,
  parameter int unsigned TICK_DIV = 65536,
  parameter int unsigned MAX_VAL  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] target,
  input  logic        target_valid,
  output logic        target_ready,
  output logic [15:0] val,
  output logic        set_val,
  output logic        busy
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [16:0]   STEP17   = 17'(STEP);
  localparam logic [15:0]   MAX16    = 16'(MAX_VAL);

`ifdef PWM_RAMP_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    LOAD   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [15:0]   tgt, tgt_n, val_n, tgt_in, step_val;
  logic [16:0]   val17, tgt17, up_sum, dn_diff;
  logic          accept;

  assign tick         = (cnt == CNT_LAST);
  assign busy         = (state != IDLE);
  assign target_ready = !rst && ((state == IDLE) || (state == RAMP));
  assign accept       = target_valid && target_ready;

  // Free-running update tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Incoming target, optionally clamped to the ceiling before it is stored.
  always_comb begin
    tgt_in = target;
    if (CLAMP_EN && (target > MAX16)) begin
      tgt_in = MAX16;
    end
  end

  // One slew step toward tgt in 17-bit space; saturates on tgt so val never overshoots.
  always_comb begin
    val17    = {1'b0, val};
    tgt17    = {1'b0, tgt};
    up_sum   = val17 + STEP17;
    dn_diff  = val17 - STEP17;
    step_val = val;
    if (tgt17 > val17) begin
      step_val = (up_sum >= tgt17) ? tgt : up_sum[15:0];
    end else if (tgt17 < val17) begin
      step_val = ((val17 < STEP17) || (dn_diff <= tgt17)) ? tgt : dn_diff[15:0];
    end
  end

  // Next-state, target and value update; a tick uses the tgt held before the edge.
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    val_n   = val;
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_n = tgt_in;
          if (tgt_in != val) begin
            state_n = RAMP;
          end
        end
      end
      RAMP: begin
        if (accept) begin
          tgt_n = tgt_in;
        end
        if (tick) begin
          if (val == tgt) begin
            // A different target arriving on this very tick keeps the ramp alive.
            state_n = (accept && (tgt_in != val)) ? RAMP : IDLE;
          end else begin
            val_n   = step_val;
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        state_n = STROBE;
      end
      STROBE: begin
        state_n = (val == tgt) ? IDLE : RAMP;
      end
      default: begin
        state_n = LOAD;
      end
    endcase
  end

  // State and output registers; reset parks in LOAD so a strobe of 0 follows release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      tgt     <= '0;
      val     <= '0;
      set_val <= 1'b0;
    end else begin
      state   <= state_n;
      tgt     <= tgt_n;
      val     <= val_n;
      set_val <= (state_n == STROBE);
    end
  end

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp with STEP=64, TICK_DIV=8, MAX_VAL=60000.
// Expected strobe values and tick phases are hand-computed from the ramp rules.
// Inputs are driven off the rising edge; outputs are sampled on the falling edge.
module tb_pwm_ramp;

  localparam int TB_DIV = 8;

  logic        clk;
  logic        rst;
  logic [15:0] target;
  logic        target_valid;
  logic        target_ready;
  logic [15:0] val;
  logic        set_val;
  logic        busy;

  int n_checks;
  int n_err;
  int tb_cnt;

  pwm_ramp #(
    .STEP     (64),
    .TICK_DIV (TB_DIV),
    .MAX_VAL  (60000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .val          (val),
    .set_val      (set_val),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference tick phase: a tick cycle has phase TB_DIV-1, so its strobe has phase 1.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt + 1) % TB_DIV;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic [15:0] t);
    int n;
    n = 0;
    @(negedge clk);
    target       = t;
    target_valid = 1'b1;
    while (!target_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, int'(target_ready), 1);
    @(posedge clk);
    #1 target_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!set_val && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, int'(set_val), 1);
    check(tag, int'(val), exp);
    check({tag, "_lat"}, tb_cnt, 1);
  endtask

  task automatic no_strobe(input string tag, input int cycles);
    int c;
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (set_val) c++;
    end
    check(tag, c, 0);
  endtask

  initial begin
    int strobes;
    int guard;
    int exp_final;
    int exp_strobes;
    n_checks     = 0;
    n_err        = 0;
    rst          = 1'b0;
    target       = '0;
    target_valid = 1'b0;
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_val",   int'(val), 0);
    check("rst_set",   int'(set_val), 0);
    check("rst_ready", int'(target_ready), 0);
    check("rst_busy",  int'(busy), 1);

    // Release: one strobe of 0, then IDLE
    rst = 1'b0;
    @(negedge clk);
    check("rel_set",   int'(set_val), 1);
    check("rel_val",   int'(val), 0);
    check("rel_ready", int'(target_ready), 0);
    @(negedge clk);
    check("rel_set_off", int'(set_val), 0);
    check("rel_ready1",  int'(target_ready), 1);
    check("rel_busy0",   int'(busy), 0);

    // Upward ramp to 200
    send("up", 16'd200);
    wait_strobe("up_64", 64);
    wait_strobe("up_128", 128);
    wait_strobe("up_192", 192);
    wait_strobe("up_200", 200);
    @(negedge clk);
    check("up_idle_busy", int'(busy), 0);
    no_strobe("up_quiet", 24);

    // From 200 down to 0 (partial last step), then retarget mid-ramp
    send("dn", 16'd0);
    wait_strobe("dn_136", 136);
    wait_strobe("dn_72", 72);
    wait_strobe("dn_8", 8);
    wait_strobe("dn_0", 0);
    send("rt", 16'd1000);
    wait_strobe("rt_64", 64);
    wait_strobe("rt_128", 128);
    send("rt_new", 16'd100);
    wait_strobe("rt_100", 100);
    @(negedge clk);
    check("rt_idle_busy", int'(busy), 0);
    no_strobe("rt_quiet", 24);

    // Accept coincident with a tick while ramping toward 1000 from 64
    send("co_a", 16'd0);
    wait_strobe("co_36", 36);
    wait_strobe("co_0", 0);
    send("co_b", 16'd1000);
    wait_strobe("co_64", 64);
    guard = 0;
    @(negedge clk);
    while (tb_cnt != TB_DIV - 1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("co_tick_ready", int'(target_ready), 1);
    target       = 16'd0;
    target_valid = 1'b1;
    @(posedge clk);
    #1 target_valid = 1'b0;
    wait_strobe("co_128", 128);
    wait_strobe("co_back_64", 64);
    wait_strobe("co_end_0", 0);
    @(negedge clk);
    check("co_idle_busy", int'(busy), 0);

    // Reset asserted during LOAD
    send("rl", 16'd1000);
    guard = 0;
    @(negedge clk);
    while (tb_cnt != TB_DIV - 1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("rl_load_val",   int'(val), 64);
    check("rl_load_set",   int'(set_val), 0);
    check("rl_load_ready", int'(target_ready), 0);
    rst = 1'b1;
    #1;
    check("rl_val",   int'(val), 0);
    check("rl_set",   int'(set_val), 0);
    check("rl_ready", int'(target_ready), 0);
    check("rl_busy",  int'(busy), 1);
    no_strobe("rl_hold", 4);
    rst = 1'b0;
    @(negedge clk);
    check("rl_rel_set", int'(set_val), 1);
    check("rl_rel_val", int'(val), 0);
    @(negedge clk);
    check("rl_rel_ready", int'(target_ready), 1);
    check("rl_rel_busy",  int'(busy), 0);

    // Full-scale ramp; ceiling depends on the clamp build option
`ifdef PWM_RAMP_CLAMP_EN
    exp_final   = 60000;
    exp_strobes = 938;
`else
    exp_final   = 65535;
    exp_strobes = 1024;
`endif
    send("fs", 16'hFFFF);
    strobes = 0;
    guard   = 0;
    @(negedge clk);
    while (busy && guard < 9000) begin
      if (set_val) strobes++;
      @(negedge clk);
      guard++;
    end
    check("fs_done",    int'(busy), 0);
    check("fs_val",     int'(val), exp_final);
    check("fs_strobes", strobes, exp_strobes);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
